// File: rtl/rtc_bcd_counter_pkg.sv
// Shared BCD types, digit limits and validation helpers for the real-time-clock counter.
package rtc_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] bcd_byte_t;

    localparam bcd_digit_t BCD_MAX_UNITS    = 4'd9;
    localparam bcd_digit_t SEC_MIN_TENS_MAX = 4'd5;

    function automatic logic bcd_valid(input bcd_byte_t value, input bcd_digit_t tens_max);
        return (value[7:4] <= tens_max) && (value[3:0] <= BCD_MAX_UNITS);
    endfunction

    // Only meaningful for bytes that already pass bcd_valid.
    function automatic logic [7:0] bcd_to_bin(input bcd_byte_t value);
        return (8'(value[7:4]) * 8'd10) + 8'(value[3:0]);
    endfunction

endpackage

// File: rtl/rtc_bcd_counter_bcd_digit_pair.sv
// Two-digit BCD counter with programmable last value (wraps to 00 after it),
// carry-in/carry-out and a parallel load that takes priority over counting.
module bcd_digit_pair
    import rtc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic [7:0] wrap_val,
    output logic [7:0] q,
    output logic [7:0] nxt,
    output logic       carry
);

    bcd_byte_t q_r;
    bcd_byte_t nxt_s;

    assign carry = inc & (q_r == wrap_val);
    assign q     = q_r;
    assign nxt   = nxt_s;

    // Next-value selection: load, wrap, units carry into tens, plain increment.
    always_comb begin
        nxt_s = q_r;
        if (load) begin
            nxt_s = load_val;
        end else if (inc) begin
            if (q_r == wrap_val) begin
                nxt_s = 8'h00;
            end else if (q_r[3:0] == BCD_MAX_UNITS) begin
                nxt_s = {q_r[7:4] + 4'd1, 4'd0};
            end else begin
                nxt_s = {q_r[7:4], q_r[3:0] + 4'd1};
            end
        end else begin
            nxt_s = q_r;
        end
    end

    // Digit-pair state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= 8'h00;
        end else begin
            q_r <= nxt_s;
        end
    end

endmodule

// File: rtl/rtc_bcd_counter.sv
// BCD hh:mm:ss time-of-day counter driven by a synchronized 1 Hz input.
// Optional alarm comparator is built when RTC_ALARM_EN is defined.
module rtc_bcd_counter
    import rtc_pkg::*;
#(
    parameter int HOURS_PER_DAY = 24,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1hz,
    input  logic       run_en,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
`ifdef RTC_ALARM_EN
    input  logic       alarm_set,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    output logic       alarm,
`endif
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       hour_pulse,
    output logic       day_pulse,
    output logic       load_err
);

    localparam int        HH_LAST  = HOURS_PER_DAY - 1;
    localparam bcd_byte_t HH_WRAP  = 8'(((HH_LAST / 10) * 16) + (HH_LAST % 10));
    localparam logic [7:0] HH_LIMIT = 8'(HOURS_PER_DAY);
    localparam bcd_byte_t MS_WRAP  = 8'h59;

    function automatic logic hh_valid(input bcd_byte_t value);
        return bcd_valid(value, BCD_MAX_UNITS) && (bcd_to_bin(value) < HH_LIMIT);
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic [SYNC_STAGES-1:0] fill_r;
    logic                   hist_r;
    logic                   tick_r;
    logic                   tick_s;
    logic                   count_s;
    logic                   load_ok_s;
    logic                   err_s;
    logic                   ss_co_s, mm_co_s, hh_co_s;
    bcd_byte_t              ss_nxt_s, mm_nxt_s, hh_nxt_s;
    logic                   sec_pulse_r, min_pulse_r, hour_pulse_r, day_pulse_r, load_err_r;

    assign tick_s  = sync_r[SYNC_STAGES-1] & ~hist_r;
    assign count_s = tick_r & run_en & ~load;
    assign load_ok_s = load & hh_valid(load_hh)
                     & bcd_valid(load_mm, SEC_MIN_TENS_MAX)
                     & bcd_valid(load_ss, SEC_MIN_TENS_MAX);

    // Synchronizer, edge history and registered tick. History is pinned high until
    // the chain has refilled after reset so a level-high input is not seen as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            fill_r <= {SYNC_STAGES{1'b0}};
            hist_r <= 1'b1;
            tick_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], clk_1hz};
            fill_r <= {fill_r[SYNC_STAGES-2:0], 1'b1};
            hist_r <= fill_r[SYNC_STAGES-1] ? sync_r[SYNC_STAGES-1] : 1'b1;
            tick_r <= tick_s;
        end
    end

    bcd_digit_pair u_ss (
        .clk(clk), .rst(rst), .inc(count_s), .load(load_ok_s),
        .load_val(load_ss), .wrap_val(MS_WRAP),
        .q(ss), .nxt(ss_nxt_s), .carry(ss_co_s)
    );

    bcd_digit_pair u_mm (
        .clk(clk), .rst(rst), .inc(ss_co_s), .load(load_ok_s),
        .load_val(load_mm), .wrap_val(MS_WRAP),
        .q(mm), .nxt(mm_nxt_s), .carry(mm_co_s)
    );

    bcd_digit_pair u_hh (
        .clk(clk), .rst(rst), .inc(mm_co_s), .load(load_ok_s),
        .load_val(load_hh), .wrap_val(HH_WRAP),
        .q(hh), .nxt(hh_nxt_s), .carry(hh_co_s)
    );

`ifdef RTC_ALARM_EN
    logic [7:0] alarm_hh_r;
    logic [7:0] alarm_mm_r;
    logic       armed_r;
    logic       alarm_r;
    logic       alarm_ok_s;
    logic       alarm_hit_s;

    assign alarm_ok_s  = alarm_set & hh_valid(alarm_hh) & bcd_valid(alarm_mm, SEC_MIN_TENS_MAX);
    assign alarm_hit_s = count_s & armed_r & (ss_nxt_s == 8'h00)
                       & (mm_nxt_s == alarm_mm_r) & (hh_nxt_s == alarm_hh_r);
    assign err_s       = (load & ~load_ok_s) | (alarm_set & ~alarm_ok_s);
    assign alarm       = alarm_r;

    // Alarm time registers and the pulse, which lines up with the counted tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_hh_r <= 8'h00;
            alarm_mm_r <= 8'h00;
            armed_r    <= 1'b0;
            alarm_r    <= 1'b0;
        end else begin
            if (alarm_ok_s) begin
                alarm_hh_r <= alarm_hh;
                alarm_mm_r <= alarm_mm;
                armed_r    <= 1'b1;
            end else begin
                alarm_hh_r <= alarm_hh_r;
                alarm_mm_r <= alarm_mm_r;
                armed_r    <= armed_r;
            end
            alarm_r <= alarm_hit_s;
        end
    end
`else
    logic unused_nxt_s;
    assign unused_nxt_s = ^{ss_nxt_s, mm_nxt_s, hh_nxt_s};
    assign err_s        = load & ~load_ok_s;
`endif

    // Rollover and load-error pulses, registered so they coincide with the new time.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_pulse_r  <= 1'b0;
            min_pulse_r  <= 1'b0;
            hour_pulse_r <= 1'b0;
            day_pulse_r  <= 1'b0;
            load_err_r   <= 1'b0;
        end else begin
            sec_pulse_r  <= count_s;
            min_pulse_r  <= ss_co_s;
            hour_pulse_r <= mm_co_s;
            day_pulse_r  <= hh_co_s;
            load_err_r   <= err_s;
        end
    end

    assign sec_pulse  = sec_pulse_r;
    assign min_pulse  = min_pulse_r;
    assign hour_pulse = hour_pulse_r;
    assign day_pulse  = day_pulse_r;
    assign load_err   = load_err_r;

endmodule
